// File: rtl/bf_core.sv
// ---------------------------------------------------------------------------
// bf_core
//
// Parametrised Brainfuck execution core. Opcodes come from a synchronous
// program RAM. Cells live in a synchronous data RAM. Byte I/O uses
// valid/ready streams. A start/halt interface reports why the core stopped.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   en              0 freezes all state and forces every strobe low
//   start           one-cycle pulse, honoured in IDLE or HALT
//   prog_addr/ren   program RAM read port; prog_rval is valid next cycle
//   data_addr       current data pointer
//   data_ren        cell read strobe; data_rval is valid next cycle
//   data_wen/wval   cell write port
//   stdin_*         input byte stream (core is the sink)
//   stdout_*        output byte stream (core is the source)
//   busy, halted    run status
//   halt_code       0 none, 1 END, 2 DP_UNDER, 3 DP_OVER, 4 STK_OVF,
//                   5 STK_UNDF, 6 UNMATCHED
// ---------------------------------------------------------------------------
module bf_core #(
    parameter int PROG_ADDR_WIDTH = 10,
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int CELL_WIDTH      = 8,
    parameter int STACK_DEPTH     = 16,
    parameter int WRAP_DP         = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       start,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    output logic                       prog_ren,
    input  logic [7:0]                 prog_rval,
    output logic [DATA_ADDR_WIDTH-1:0] data_addr,
    output logic                       data_ren,
    input  logic [CELL_WIDTH-1:0]      data_rval,
    output logic                       data_wen,
    output logic [CELL_WIDTH-1:0]      data_wval,
    input  logic [7:0]                 stdin_data,
    input  logic                       stdin_valid,
    output logic                       stdin_ready,
    output logic [7:0]                 stdout_data,
    output logic                       stdout_valid,
    input  logic                       stdout_ready,
    output logic                       busy,
    output logic                       halted,
    output logic [2:0]                 halt_code
);

    localparam int PROG_DEPTH  = 2 ** PROG_ADDR_WIDTH;
    localparam int DEPTH_WIDTH = $clog2(PROG_DEPTH) + 1;
    localparam int SP_WIDTH    = $clog2(STACK_DEPTH + 1);
    localparam int SIDX_WIDTH  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    localparam logic [2:0] HC_NONE      = 3'd0;
    localparam logic [2:0] HC_END       = 3'd1;
    localparam logic [2:0] HC_DP_UNDER  = 3'd2;
    localparam logic [2:0] HC_DP_OVER   = 3'd3;
    localparam logic [2:0] HC_STK_OVF   = 3'd4;
    localparam logic [2:0] HC_STK_UNDF  = 3'd5;
    localparam logic [2:0] HC_UNMATCHED = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_IN_WAIT,
        S_OUT_WAIT,
        S_SKIP_F,
        S_SKIP_D,
        S_HALT
    } state_t;

    state_t                     state, state_n;
    logic [PROG_ADDR_WIDTH-1:0] pc, pc_n;
    logic [DATA_ADDR_WIDTH-1:0] dp, dp_n;
    logic [SP_WIDTH-1:0]        sp, sp_n;
    logic [DEPTH_WIDTH-1:0]     depth, depth_n;
    logic [2:0]                 halt_code_n;
    logic                       wr_pend, wr_pend_n;
    logic [CELL_WIDTH-1:0]      data_wval_n;
    logic [7:0]                 stdout_data_n;
    logic                       push_en;

    logic [PROG_ADDR_WIDTH-1:0] stack [STACK_DEPTH];

    logic [PROG_ADDR_WIDTH-1:0] pc_inc;
    logic                       pc_last;
    logic [SP_WIDTH-1:0]        sp_m1;
    logic [SIDX_WIDTH-1:0]      push_idx;
    logic [SIDX_WIDTH-1:0]      top_idx;
    state_t                     adv_state;
    state_t                     skip_state;
    logic [PROG_ADDR_WIDTH-1:0] adv_pc;
    logic [2:0]                 adv_code;

    // Stepping past the last program address ends the run instead of
    // wrapping, so every "pc+1" site uses these pre-computed outcomes.
    assign pc_inc     = pc + PROG_ADDR_WIDTH'(1);
    assign pc_last    = &pc;
    assign adv_state  = pc_last ? S_HALT : S_FETCH;
    assign skip_state = pc_last ? S_HALT : S_SKIP_F;
    assign adv_pc     = pc_last ? pc : pc_inc;
    assign adv_code   = pc_last ? HC_END : halt_code;

    assign sp_m1    = sp - SP_WIDTH'(1);
    assign push_idx = sp[SIDX_WIDTH-1:0];
    assign top_idx  = sp_m1[SIDX_WIDTH-1:0];

    // Strobes come only from registered state and are all masked by en.
    // Cell writes are posted: EXEC/IN_WAIT register the value and raise
    // wr_pend, and the RAM takes it during the following cycle, which is
    // always FETCH or HALT, so dp has not moved yet.
    assign prog_addr    = pc;
    assign prog_ren     = en && (state == S_FETCH || state == S_SKIP_F);
    assign data_addr    = dp;
    assign data_ren     = en && (state == S_READ);
    assign data_wen     = en && wr_pend;
    assign stdin_ready  = en && (state == S_IN_WAIT);
    assign stdout_valid = en && (state == S_OUT_WAIT);
    assign busy         = (state != S_IDLE) && (state != S_HALT);
    assign halted       = (state == S_HALT);

    // Next-state and datapath decode. Every path starts from "hold", and
    // the non-halting paths then pick up the shared pc+1 outcome.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        dp_n          = dp;
        sp_n          = sp;
        depth_n       = depth;
        halt_code_n   = halt_code;
        wr_pend_n     = 1'b0;
        data_wval_n   = data_wval;
        stdout_data_n = stdout_data;
        push_en       = 1'b0;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n        = '0;
                    dp_n        = '0;
                    sp_n        = '0;
                    depth_n     = '0;
                    halt_code_n = HC_NONE;
                    state_n     = S_FETCH;
                end
            end

            S_FETCH: state_n = S_DECODE;

            S_DECODE: begin
                state_n     = adv_state;
                pc_n        = adv_pc;
                halt_code_n = adv_code;
                case (prog_rval)
                    OP_RIGHT: begin
                        if (&dp && WRAP_DP == 0) begin
                            state_n     = S_HALT;
                            pc_n        = pc;
                            halt_code_n = HC_DP_OVER;
                        end else begin
                            dp_n = dp + DATA_ADDR_WIDTH'(1);
                        end
                    end
                    OP_LEFT: begin
                        if (dp == '0 && WRAP_DP == 0) begin
                            state_n     = S_HALT;
                            pc_n        = pc;
                            halt_code_n = HC_DP_UNDER;
                        end else begin
                            dp_n = dp - DATA_ADDR_WIDTH'(1);
                        end
                    end
                    OP_INC, OP_DEC, OP_OUT, OP_OPEN, OP_CLOSE: begin
                        state_n     = S_READ;
                        pc_n        = pc;
                        halt_code_n = halt_code;
                    end
                    OP_IN: begin
                        state_n     = S_IN_WAIT;
                        pc_n        = pc;
                        halt_code_n = halt_code;
                    end
                    OP_END: begin
                        state_n     = S_HALT;
                        pc_n        = pc;
                        halt_code_n = HC_END;
                    end
                    default: ;
                endcase
            end

            S_READ: state_n = S_EXEC;

            // prog_rval is still the current opcode here: nothing has
            // strobed the program RAM since DECODE.
            S_EXEC: begin
                state_n     = adv_state;
                pc_n        = adv_pc;
                halt_code_n = adv_code;
                case (prog_rval)
                    OP_INC: begin
                        wr_pend_n   = 1'b1;
                        data_wval_n = data_rval + CELL_WIDTH'(1);
                    end
                    OP_DEC: begin
                        wr_pend_n   = 1'b1;
                        data_wval_n = data_rval - CELL_WIDTH'(1);
                    end
                    OP_OUT: begin
                        stdout_data_n = data_rval[7:0];
                        state_n       = S_OUT_WAIT;
                        pc_n          = pc;
                        halt_code_n   = halt_code;
                    end
                    OP_OPEN: begin
                        if (data_rval == '0) begin
                            depth_n = DEPTH_WIDTH'(1);
                            state_n = skip_state;
                        end else if (sp == SP_WIDTH'(STACK_DEPTH)) begin
                            state_n     = S_HALT;
                            pc_n        = pc;
                            halt_code_n = HC_STK_OVF;
                        end else begin
                            push_en = 1'b1;
                            sp_n    = sp + SP_WIDTH'(1);
                        end
                    end
                    OP_CLOSE: begin
                        if (sp == '0) begin
                            state_n     = S_HALT;
                            pc_n        = pc;
                            halt_code_n = HC_STK_UNDF;
                        end else if (data_rval != '0) begin
                            state_n     = S_FETCH;
                            pc_n        = stack[top_idx];
                            halt_code_n = halt_code;
                        end else begin
                            sp_n = sp_m1;
                        end
                    end
                    default: ;
                endcase
            end

            S_IN_WAIT: begin
                if (stdin_valid) begin
                    wr_pend_n   = 1'b1;
                    data_wval_n = CELL_WIDTH'(stdin_data);
                    state_n     = adv_state;
                    pc_n        = adv_pc;
                    halt_code_n = adv_code;
                end
            end

            S_OUT_WAIT: begin
                if (stdout_ready) begin
                    state_n     = adv_state;
                    pc_n        = adv_pc;
                    halt_code_n = adv_code;
                end
            end

            S_SKIP_F: state_n = S_SKIP_D;

            // Forward skip only tracks bracket depth; the stack is
            // untouched until the matching ']' is found.
            S_SKIP_D: begin
                state_n     = skip_state;
                pc_n        = adv_pc;
                halt_code_n = adv_code;
                case (prog_rval)
                    OP_OPEN: depth_n = depth + DEPTH_WIDTH'(1);
                    OP_CLOSE: begin
                        depth_n = depth - DEPTH_WIDTH'(1);
                        if (depth == DEPTH_WIDTH'(1)) begin
                            state_n = adv_state;
                        end
                    end
                    OP_END: begin
                        state_n     = S_HALT;
                        pc_n        = pc;
                        halt_code_n = HC_UNMATCHED;
                    end
                    default: ;
                endcase
            end

            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset wins over everything and drops
    // any in-flight handshake or posted write; en=0 simply holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            dp          <= '0;
            sp          <= '0;
            depth       <= '0;
            halt_code   <= HC_NONE;
            wr_pend     <= 1'b0;
            data_wval   <= '0;
            stdout_data <= '0;
        end else if (en) begin
            state       <= state_n;
            pc          <= pc_n;
            dp          <= dp_n;
            sp          <= sp_n;
            depth       <= depth_n;
            halt_code   <= halt_code_n;
            wr_pend     <= wr_pend_n;
            data_wval   <= data_wval_n;
            stdout_data <= stdout_data_n;
        end
    end

    // Loop return stack. It stores the address just after each '[', so a
    // taken ']' jumps straight to the loop body.
    always_ff @(posedge clk) begin
        if (!reset && en && push_en) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_bf_core.sv
// ---------------------------------------------------------------------------
// tb_bf_core
//
// Directed bench for bf_core. It uses two instances.
//   A: 64-byte program, 16 cells, 8-bit cells, stack depth 2, no dp wrap.
//   B: 16-byte program, 8 cells, 16-bit cells, stack depth 4, dp wrap.
// Each instance has a behavioural program RAM, a behavioural cell RAM and a
// stdout sink that logs every accepted byte.
// ---------------------------------------------------------------------------
module tb_bf_core;

    localparam int A_PAW = 6;
    localparam int A_DAW = 4;
    localparam int A_CW  = 8;
    localparam int B_PAW = 4;
    localparam int B_DAW = 3;
    localparam int B_CW  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       start_a;
    logic       start_b;
    logic [7:0] stdin_data;
    logic       stdin_valid;
    logic       stdout_ready;

    logic [A_PAW-1:0] prog_addr_a;
    logic             prog_ren_a;
    logic [7:0]       prog_rval_a;
    logic [A_DAW-1:0] data_addr_a;
    logic             data_ren_a;
    logic [A_CW-1:0]  data_rval_a;
    logic             data_wen_a;
    logic [A_CW-1:0]  data_wval_a;
    logic             stdin_ready_a;
    logic [7:0]       stdout_data_a;
    logic             stdout_valid_a;
    logic             busy_a;
    logic             halted_a;
    logic [2:0]       halt_code_a;

    logic [B_PAW-1:0] prog_addr_b;
    logic             prog_ren_b;
    logic [7:0]       prog_rval_b;
    logic [B_DAW-1:0] data_addr_b;
    logic             data_ren_b;
    logic [B_CW-1:0]  data_rval_b;
    logic             data_wen_b;
    logic [B_CW-1:0]  data_wval_b;
    logic             stdin_ready_b;
    logic [7:0]       stdout_data_b;
    logic             stdout_valid_b;
    logic             busy_b;
    logic             halted_b;
    logic [2:0]       halt_code_b;

    logic [7:0]      prog_mem_a [2**A_PAW];
    logic [A_CW-1:0] data_mem_a [2**A_DAW];
    logic [7:0]      prog_mem_b [2**B_PAW];
    logic [B_CW-1:0] data_mem_b [2**B_DAW];
    logic [7:0]      out_a [$];
    logic [7:0]      out_b [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bf_core #(
        .PROG_ADDR_WIDTH(A_PAW), .DATA_ADDR_WIDTH(A_DAW), .CELL_WIDTH(A_CW),
        .STACK_DEPTH(2), .WRAP_DP(0)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en), .start(start_a),
        .prog_addr(prog_addr_a), .prog_ren(prog_ren_a), .prog_rval(prog_rval_a),
        .data_addr(data_addr_a), .data_ren(data_ren_a), .data_rval(data_rval_a),
        .data_wen(data_wen_a), .data_wval(data_wval_a),
        .stdin_data(stdin_data), .stdin_valid(stdin_valid), .stdin_ready(stdin_ready_a),
        .stdout_data(stdout_data_a), .stdout_valid(stdout_valid_a), .stdout_ready(stdout_ready),
        .busy(busy_a), .halted(halted_a), .halt_code(halt_code_a)
    );

    bf_core #(
        .PROG_ADDR_WIDTH(B_PAW), .DATA_ADDR_WIDTH(B_DAW), .CELL_WIDTH(B_CW),
        .STACK_DEPTH(4), .WRAP_DP(1)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en), .start(start_b),
        .prog_addr(prog_addr_b), .prog_ren(prog_ren_b), .prog_rval(prog_rval_b),
        .data_addr(data_addr_b), .data_ren(data_ren_b), .data_rval(data_rval_b),
        .data_wen(data_wen_b), .data_wval(data_wval_b),
        .stdin_data(stdin_data), .stdin_valid(stdin_valid), .stdin_ready(stdin_ready_b),
        .stdout_data(stdout_data_b), .stdout_valid(stdout_valid_b), .stdout_ready(stdout_ready),
        .busy(busy_b), .halted(halted_b), .halt_code(halt_code_b)
    );

    // Memory and stdout sink models act at the clock edge, like the real
    // RAMs and stream glue. They see pre-edge DUT outputs.
    always @(posedge clk) begin
        if (prog_ren_a) prog_rval_a <= prog_mem_a[prog_addr_a];
        if (data_ren_a) data_rval_a <= data_mem_a[data_addr_a];
        if (data_wen_a) data_mem_a[data_addr_a] = data_wval_a;
        if (stdout_valid_a && stdout_ready) out_a.push_back(stdout_data_a);
        if (prog_ren_b) prog_rval_b <= prog_mem_b[prog_addr_b];
        if (data_ren_b) data_rval_b <= data_mem_b[data_addr_b];
        if (data_wen_b) data_mem_b[data_addr_b] = data_wval_b;
        if (stdout_valid_b && stdout_ready) out_b.push_back(stdout_data_b);
    end

    // Loads a program. Unused space is filled with 0x00 (END). The cells are
    // optionally cleared and the stdout log is emptied.
    task automatic load_prog(input bit use_b, input string p, input bit clear_data);
        if (!use_b) begin
            for (int i = 0; i < 2**A_PAW; i++) prog_mem_a[i] = 8'h00;
            for (int i = 0; i < p.len(); i++) prog_mem_a[i] = p[i];
            if (clear_data) for (int i = 0; i < 2**A_DAW; i++) data_mem_a[i] = '0;
            out_a.delete();
        end else begin
            for (int i = 0; i < 2**B_PAW; i++) prog_mem_b[i] = 8'h00;
            for (int i = 0; i < p.len() && i < 2**B_PAW; i++) prog_mem_b[i] = p[i];
            if (clear_data) for (int i = 0; i < 2**B_DAW; i++) data_mem_b[i] = '0;
            out_b.delete();
        end
    endtask

    // Pulses start and waits, bounded, for HALT. It counts busy cycles.
    task automatic run_prog(input bit use_b, input int limit, input string name,
                            output int busy_cycles);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < limit && !(use_b ? halted_b : halted_a); c++) begin
            if (use_b ? busy_b : busy_a) busy_cycles++;
            @(negedge clk);
        end
        checks++;
        if ((use_b ? halted_b : halted_a) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_timeout: halted=%0b, required 1", name,
                     use_b ? halted_b : halted_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, halted_a, halt_code_a, busy_b, halted_b, halt_code_b} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_status: busy/halted/code a=%b%b%0d b=%b%b%0d, required all 0",
                     busy_a, halted_a, halt_code_a, busy_b, halted_b, halt_code_b);
        end
        checks++;
        if ({prog_ren_a, data_ren_a, data_wen_a, stdin_ready_a, stdout_valid_a,
             prog_ren_b, data_ren_b, data_wen_b, stdin_ready_b, stdout_valid_b} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: a=%b%b%b%b%b b=%b%b%b%b%b, required 0",
                     prog_ren_a, data_ren_a, data_wen_a, stdin_ready_a, stdout_valid_a,
                     prog_ren_b, data_ren_b, data_wen_b, stdin_ready_b, stdout_valid_b);
        end
        checks++;
        if (data_wval_a !== 8'h00 || stdout_data_a !== 8'h00 || data_addr_a !== 4'h0 ||
            prog_addr_a !== 6'h00 || data_wval_b !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_values: wval=%h out=%h dp=%h pc=%h wval_b=%h, required 0",
                     data_wval_a, stdout_data_a, data_addr_a, prog_addr_a, data_wval_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_output();
        int cyc;
        load_prog(1'b0, "+++.", 1'b1);
        stdout_ready = 1'b1;
        run_prog(1'b0, 100, "output", cyc);
        // Three '+' at 4 cycles, '.' at 4 plus 1 handshake, END at 2.
        checks++;
        if (cyc !== 19) begin
            errors++;
            $display("[TB] FAIL output_latency: busy cycles=%0d, required 19", cyc);
        end
        checks++;
        if (out_a.size() !== 1 || out_a[0] !== 8'h03) begin
            errors++;
            $display("[TB] FAIL output_beat: beats=%0d first=%h, required 1 beat of 03",
                     out_a.size(), out_a.size() > 0 ? out_a[0] : 8'hxx);
        end
        checks++;
        if (halt_code_a !== 3'd1 || data_mem_a[0] !== 8'h03) begin
            errors++;
            $display("[TB] FAIL output_end: code=%0d cell0=%h, required 1 and 03",
                     halt_code_a, data_mem_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Restart from HALT without clearing the cells. cell0 goes 3 -> 6.
        load_prog(1'b0, "+++.", 1'b0);
        run_prog(1'b0, 100, "b2b", cyc);
        checks++;
        if (out_a.size() !== 1 || out_a[0] !== 8'h06 || halt_code_a !== 3'd1) begin
            errors++;
            $display("[TB] FAIL b2b_beat: beats=%0d first=%h code=%0d, required 1 beat of 06, code 1",
                     out_a.size(), out_a.size() > 0 ? out_a[0] : 8'hxx, halt_code_a);
        end
    endtask

    task automatic test_input_stall();
        int stall_n = 0;
        int stall_good = 0;
        load_prog(1'b0, ",+.", 1'b1);
        stdin_data   = 8'h41;
        stdin_valid  = 1'b1;
        stdout_ready = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 200 && !halted_a; c++) begin
            en = !(c == 1 || c == 6);
            #1;
            if (!en) begin
                checks++;
                if ({prog_ren_a, data_ren_a, data_wen_a, stdin_ready_a, stdout_valid_a} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL en_low_strobes: %b%b%b%b%b, required 00000",
                             prog_ren_a, data_ren_a, data_wen_a, stdin_ready_a, stdout_valid_a);
                end
            end
            if (stdout_valid_a && !stdout_ready) begin
                stall_n++;
                if (stdout_data_a === 8'h42) stall_good++;
                if (stall_n == 5) stdout_ready = 1'b1;
            end
            @(negedge clk);
        end
        en          = 1'b1;
        stdin_valid = 1'b0;
        checks++;
        if (halted_a !== 1'b1 || halt_code_a !== 3'd1) begin
            errors++;
            $display("[TB] FAIL input_end: halted=%b code=%0d, required 1 and 1", halted_a, halt_code_a);
        end
        checks++;
        if (stall_n !== 5 || stall_good !== 5) begin
            errors++;
            $display("[TB] FAIL stall_stable: stalled=%0d good=%0d, required 5 and 5",
                     stall_n, stall_good);
        end
        checks++;
        if (out_a.size() !== 1 || out_a[0] !== 8'h42 || data_mem_a[0] !== 8'h42) begin
            errors++;
            $display("[TB] FAIL input_beat: beats=%0d first=%h cell0=%h, required 1 beat of 42, cell 42",
                     out_a.size(), out_a.size() > 0 ? out_a[0] : 8'hxx, data_mem_a[0]);
        end
    endtask

    task automatic test_skip();
        int cyc;
        load_prog(1'b0, "[+[-]].", 1'b1);
        run_prog(1'b0, 200, "skip", cyc);
        checks++;
        if (out_a.size() !== 1 || out_a[0] !== 8'h00 || halt_code_a !== 3'd1 ||
            data_mem_a[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL skip_nested: beats=%0d first=%h code=%0d cell0=%h, required 1 beat 00, code 1, cell 00",
                     out_a.size(), out_a.size() > 0 ? out_a[0] : 8'hxx, halt_code_a, data_mem_a[0]);
        end
        load_prog(1'b0, "[", 1'b1);
        run_prog(1'b0, 100, "unmatched", cyc);
        checks++;
        if (halt_code_a !== 3'd6) begin
            errors++;
            $display("[TB] FAIL unmatched_code: code=%0d, required 6", halt_code_a);
        end
    endtask

    task automatic test_loop();
        int cyc;
        load_prog(1'b0, "++[>+<-]>.", 1'b1);
        run_prog(1'b0, 400, "loop", cyc);
        checks++;
        if (out_a.size() !== 1 || out_a[0] !== 8'h02 || halt_code_a !== 3'd1) begin
            errors++;
            $display("[TB] FAIL loop_beat: beats=%0d first=%h code=%0d, required 1 beat of 02, code 1",
                     out_a.size(), out_a.size() > 0 ? out_a[0] : 8'hxx, halt_code_a);
        end
        checks++;
        if (data_mem_a[0] !== 8'h00 || data_mem_a[1] !== 8'h02 || dut_a.sp !== '0) begin
            errors++;
            $display("[TB] FAIL loop_state: cell0=%h cell1=%h sp=%0d, required 00 02 0",
                     data_mem_a[0], data_mem_a[1], dut_a.sp);
        end
    endtask

    task automatic test_errors();
        int cyc;
        string s = "";
        load_prog(1'b0, "+[[[", 1'b1);
        run_prog(1'b0, 100, "stk_ovf", cyc);
        checks++;
        if (halt_code_a !== 3'd4) begin
            errors++;
            $display("[TB] FAIL stk_ovf_code: code=%0d, required 4", halt_code_a);
        end
        load_prog(1'b0, "]", 1'b1);
        run_prog(1'b0, 100, "stk_undf", cyc);
        checks++;
        if (halt_code_a !== 3'd5) begin
            errors++;
            $display("[TB] FAIL stk_undf_code: code=%0d, required 5", halt_code_a);
        end
        load_prog(1'b0, "<", 1'b1);
        run_prog(1'b0, 100, "dp_under", cyc);
        checks++;
        if (halt_code_a !== 3'd2 || data_addr_a !== 4'h0) begin
            errors++;
            $display("[TB] FAIL dp_under: code=%0d dp=%0d, required 2 and 0", halt_code_a, data_addr_a);
        end
        for (int i = 0; i < 16; i++) s = {s, ">"};
        load_prog(1'b0, s, 1'b1);
        run_prog(1'b0, 200, "dp_over", cyc);
        checks++;
        if (halt_code_a !== 3'd3 || data_addr_a !== 4'hF) begin
            errors++;
            $display("[TB] FAIL dp_over: code=%0d dp=%0d, required 3 and 15", halt_code_a, data_addr_a);
        end
    endtask

    task automatic test_wide_wrap();
        int cyc;
        string s = "";
        load_prog(1'b1, "-.", 1'b1);
        stdout_ready = 1'b1;
        run_prog(1'b1, 100, "wide", cyc);
        checks++;
        if (out_b.size() !== 1 || out_b[0] !== 8'hFF || data_mem_b[0] !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wide_cell: beats=%0d first=%h cell0=%h, required 1 beat FF, cell FFFF",
                     out_b.size(), out_b.size() > 0 ? out_b[0] : 8'hxx, data_mem_b[0]);
        end
        load_prog(1'b1, "<", 1'b1);
        run_prog(1'b1, 100, "wrap", cyc);
        checks++;
        if (halt_code_b !== 3'd1 || data_addr_b !== 3'd7) begin
            errors++;
            $display("[TB] FAIL dp_wrap: code=%0d dp=%0d, required 1 and 7", halt_code_b, data_addr_b);
        end
        // 16 no-op bytes fill the whole program space. Stepping past the
        // last address must end the run after 16 x 2 cycles.
        for (int i = 0; i < 16; i++) s = {s, "x"};
        load_prog(1'b1, s, 1'b1);
        run_prog(1'b1, 200, "pc_end", cyc);
        checks++;
        if (halt_code_b !== 3'd1 || cyc !== 32) begin
            errors++;
            $display("[TB] FAIL pc_end: code=%0d cycles=%0d, required 1 and 32", halt_code_b, cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        load_prog(1'b0, "+.", 1'b1);
        stdout_ready = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (stdout_valid_a) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait: stdout_valid=%b, required 1 before timeout", stdout_valid_a);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (stdout_valid_a !== 1'b0 || busy_a !== 1'b0 || halted_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: valid=%b busy=%b halted=%b, required 0 0 0",
                     stdout_valid_a, busy_a, halted_a);
        end
        reset = 1'b0;
        stdout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_a.size() !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_beats: beats=%0d, required 0", out_a.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b1;
        start_a      = 1'b0;
        start_b      = 1'b0;
        stdin_data   = 8'h00;
        stdin_valid  = 1'b0;
        stdout_ready = 1'b1;
        prog_rval_a  = 8'h00;
        prog_rval_b  = 8'h00;
        data_rval_a  = '0;
        data_rval_b  = '0;
        $display("[TB] bf_core directed tests starting");
        test_reset();
        test_output();
        test_back_to_back();
        test_input_stall();
        test_skip();
        test_loop();
        test_errors();
        test_wide_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
